cic_decim_param: RTL and testbench
==================================

Name: cic_decim_param

Overview:
- Parametrised Nth-order CIC decimator, successor to the fixed 3rd-order, D=256 filter.
- Runs entirely on the modulator clock. An internal decimation counter generates the comb update strobe, so there is no externally divided clock.
- Supports:
  - NUM_CH parallel 1-bit sigma-delta channels sharing one counter.
  - Decimation ratio 2^decim_log2, selectable at run time.
  - Unipolar or bipolar input coding.
  - Scaled, saturated OUT_WIDTH output with a valid/ready handshake.
- Sits between the modulator bitstreams and the readout/monitor logic.

Parameters:
- ORDER, 3, number of integrator and comb stages (1..5).
- MAX_DECIM_LOG2, 8, log2 of the largest decimation ratio (1..12).
- NUMBITS, ORDER*MAX_DECIM_LOG2+1, internal register width. Derived; do not override.
- OUT_WIDTH, 16, signed output word width per channel (2..NUMBITS).
- NUM_CH, 1, number of independent channels (1..8).
- DL_W, $clog2(MAX_DECIM_LOG2+1), width of decim_log2. Derived.

Ports:
- clk  input  1  modulator clock. Single clock domain.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run control. Low clears state synchronously.
- bipolar  input  1  input coding: 0 → bit 1 = +1, bit 0 = 0; 1 → bit 1 = +1, bit 0 = −1.
- decim_log2  input  DL_W  requested log2 of decimation ratio.
- in  input  NUM_CH  modulator bitstreams, bit k = channel k.
- out  output  NUM_CH*OUT_WIDTH  signed results, channel k in bits [k*OUT_WIDTH +: OUT_WIDTH].
- out_valid  output  1  out holds an unread sample.
- out_ready  input  1  consumer accepts sample when out_valid && out_ready at a rising clk edge.
- overrun  output  1  sticky flag: an unread sample was overwritten.
- sat  output  NUM_CH  per-channel flag: current out word was clipped. Updated with each load.

Behaviour:
- Reset (asynchronous, any time, including mid-frame) clears to zero: all integrators, comb delays, counter, warm-up count, out, out_valid, overrun, sat. The latched ratio dl_act is set to the clamp of decim_log2.
- Clamp rule: dl_act = decim_log2, forced to 1 if 0 and to MAX_DECIM_LOG2 if larger. dl_act is latched only:
  - on a tick,
  - while enable is low,
  - at reset.
- Integrators: each cycle with enable high,
  - acc1 += coded(in);
  - acc_k += acc_{k-1} (old value) for k = 2..ORDER.
  - Arithmetic is modulo 2^NUMBITS two's complement. Wrap-around is intentional.
- Counter: counts enabled cycles 0..2^dl_act−1. tick = enable && count == 2^dl_act−1; the counter returns to 0 on tick.
- Combs: on tick only, chained combinationally from acc_ORDER. Stage k result c_k = c_{k−1} − d_k, where c_0 = acc_ORDER. Each d_k is then updated to c_{k−1}. Arithmetic is modulo 2^NUMBITS.
- Scaling: let S = ORDER*dl_act + 1 − OUT_WIDTH.
  - If S ≥ 0: arithmetic right shift c_ORDER by S.
  - If S < 0: left shift by −S.
  - Then saturate to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1] and set sat[k] if clipped.
- Output load: one cycle after tick (latency 1 clk), out and sat load, and out_valid is set.
- Warm-up: the first ORDER ticks after reset, after enable rises, or after dl_act changes are suppressed. Combs still update; out, out_valid and sat do not. The first load occurs on tick ORDER+1.
- Handshake:
  - out_valid clears on the accept edge.
  - If a load and an accept coincide, the new sample loads, out_valid stays 1, and overrun is not set.
  - If a load occurs with out_valid=1 and no accept, out is overwritten and overrun is set (sticky).
- enable low, synchronous clear: integrators, combs, counter, warm-up count, out_valid and overrun are cleared. out and sat hold. in is ignored.
- A bipolar change mid-run takes effect the next cycle. No restart.

Test Plan:
- ORDER=3, dl=8, OUT_WIDTH=16, unipolar, in constant 1, out_ready=1 → first valid on tick 4. out=32767, sat=1 (steady state 2^24 shifted by 9 = 32768, clipped).
- Same config, bipolar, in constant 0 → every valid out = −32768, sat=0. Alternating 1/0 → out = 0. Unipolar alternating 1/0 → out = 16384.
- decim_log2=0, then 15 → dl_act=1 (tick every 2 cycles, S=−12), then 8 → after change, exactly 3 suppressed ticks before the next out_valid.
- out_ready held 0 across two loads → overrun=1 and out holds the second sample. Pulse enable low 1 cycle → overrun=0, out_valid=0, out unchanged.
- Assert reset mid-frame (count=100) and release → all outputs 0 immediately. Counter restarts, first valid after 4 ticks.
- NUM_CH=2, ch0 constant 1, ch1 constant 0, unipolar → ch0 = 32767 with sat[0]=1; ch1 = 0 with sat[1]=0. Loads are simultaneous.

Source files
------------

// File: rtl/cic_decim_param.sv
// Parametrised Nth-order CIC decimator for NUM_CH 1-bit sigma-delta streams on the
// modulator clock: run-time ratio 2^decim_log2, scaled/saturated output, valid/ready.
module cic_decim_param #(
    parameter int unsigned ORDER          = 3,
    parameter int unsigned MAX_DECIM_LOG2 = 8,
    parameter int unsigned NUMBITS        = ORDER * MAX_DECIM_LOG2 + 1,
    parameter int unsigned OUT_WIDTH      = 16,
    parameter int unsigned NUM_CH         = 1,
    parameter int unsigned DL_W           = $clog2(MAX_DECIM_LOG2 + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        bipolar,
    input  logic [DL_W-1:0]             decim_log2,
    input  logic [NUM_CH-1:0]           in,
    output logic [NUM_CH*OUT_WIDTH-1:0] out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overrun,
    output logic [NUM_CH-1:0]           sat
);

    localparam int unsigned CNT_W  = MAX_DECIM_LOG2;
    localparam int unsigned WARM_W = $clog2(ORDER + 1);
    localparam int unsigned EXT_W  = 2 * NUMBITS;
    localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((64'(1) << (OUT_WIDTH - 1)) - 64'(1));
    localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

    function automatic logic [DL_W-1:0] clamp_dl(input logic [DL_W-1:0] v);
        logic [DL_W-1:0] r;
        r = v;
        if (v == '0) begin
            r = DL_W'(1);
        end else if (32'(v) > MAX_DECIM_LOG2) begin
            r = DL_W'(MAX_DECIM_LOG2);
        end
        return r;
    endfunction

    logic [NUM_CH-1:0][ORDER-1:0][NUMBITS-1:0] acc_q, acc_d, dly_q, dly_d;
    logic [NUM_CH-1:0][OUT_WIDTH-1:0]          out_q, out_d;
    logic [NUM_CH-1:0]                         sat_q, sat_d;
    logic [CNT_W-1:0]                          cnt_q, cnt_d, cnt_max;
    logic [CNT_W:0]                            span;
    logic [DL_W-1:0]                           dl_act_q, dl_act_d, dl_act, dl_req;
    logic [WARM_W-1:0]                         warm_q, warm_d;
    logic                                      out_valid_q, out_valid_d;
    logic                                      overrun_q, overrun_d;
    logic                                      tick, load, accept;
    logic [NUMBITS-1:0]                        coded, c_cur, c_prev;
    logic signed [EXT_W-1:0]                   ext, scaled;
    int                                        shift_s;

    // dl_act_q == 0 marks "not latched since reset": the live clamped request is used
    // until the first clock, so reset itself needs no data-dependent async load.
    assign dl_req = clamp_dl(decim_log2);
    assign dl_act = (dl_act_q == '0) ? dl_req : dl_act_q;

    always_comb begin
        span    = (CNT_W + 1)'(1) << dl_act;
        cnt_max = CNT_W'(span - (CNT_W + 1)'(1));
        tick    = enable && (cnt_q == cnt_max);
        load    = tick && (warm_q == WARM_W'(ORDER));
        accept  = out_valid_q && out_ready;
        shift_s = int'(ORDER) * int'(dl_act) + 1 - int'(OUT_WIDTH);
    end

    always_comb begin
        acc_d       = acc_q;
        dly_d       = dly_q;
        cnt_d       = cnt_q;
        warm_d      = warm_q;
        dl_act_d    = dl_act_q;
        out_d       = out_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        coded       = '0;
        c_cur       = '0;
        c_prev      = '0;
        ext         = '0;
        scaled      = '0;

        if (!enable || tick || (dl_act_q == '0)) begin
            dl_act_d = dl_req;
        end

        for (int ch = 0; ch < int'(NUM_CH); ch++) begin
            coded = in[ch] ? NUMBITS'(1) : (bipolar ? '1 : '0);
            acc_d[ch][0] = acc_q[ch][0] + coded;
            for (int k = 1; k < int'(ORDER); k++) begin
                acc_d[ch][k] = acc_q[ch][k] + acc_q[ch][k-1];
            end

            // Comb chain evaluated combinationally; delays only advance on tick.
            c_cur = acc_q[ch][ORDER-1];
            for (int k = 0; k < int'(ORDER); k++) begin
                c_prev = c_cur;
                c_cur  = c_cur - dly_q[ch][k];
                if (tick) begin
                    dly_d[ch][k] = c_prev;
                end
            end

            // Unipolar results are non-negative, so the top bit is magnitude, not sign.
            ext = bipolar ? {{NUMBITS{c_cur[NUMBITS-1]}}, c_cur} : {{NUMBITS{1'b0}}, c_cur};
            if (shift_s >= 0) begin
                scaled = ext >>> shift_s;
            end else begin
                scaled = ext <<< (-shift_s);
            end

            if (load) begin
                sat_d[ch] = 1'b0;
                out_d[ch] = OUT_WIDTH'(scaled);
                if (scaled > OUT_MAX) begin
                    out_d[ch] = OUT_WIDTH'(OUT_MAX);
                    sat_d[ch] = 1'b1;
                end else if (scaled < OUT_MIN) begin
                    out_d[ch] = OUT_WIDTH'(OUT_MIN);
                    sat_d[ch] = 1'b1;
                end
            end
        end

        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
        if (tick) begin
            if (dl_req != dl_act) begin
                warm_d = '0;
            end else if (warm_q != WARM_W'(ORDER)) begin
                warm_d = warm_q + WARM_W'(1);
            end
        end

        if (accept) begin
            out_valid_d = 1'b0;
        end
        if (load) begin
            out_valid_d = 1'b1;
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end

        if (!enable) begin
            acc_d       = '0;
            dly_d       = '0;
            cnt_d       = '0;
            warm_d      = '0;
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            dly_q       <= '0;
            cnt_q       <= '0;
            warm_q      <= '0;
            dl_act_q    <= '0;
            out_q       <= '0;
            sat_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            dly_q       <= dly_d;
            cnt_q       <= cnt_d;
            warm_q      <= warm_d;
            dl_act_q    <= dl_act_d;
            out_q       <= out_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out       = out_q;
    assign sat       = sat_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_decim_param.sv
// Directed bench for cic_decim_param (ORDER=3, MAX_DECIM_LOG2=8, OUT_WIDTH=16, 2 channels)
// with hand-computed expected words, warm-up latencies and handshake flags.
module tb_cic_decim_param;

    localparam int unsigned ORDER     = 3;
    localparam int unsigned MAXDL     = 8;
    localparam int unsigned OUT_WIDTH = 16;
    localparam int unsigned NUM_CH    = 2;
    localparam int unsigned DL_W      = 4;

    logic                        clk;
    logic                        reset;
    logic                        enable;
    logic                        bipolar;
    logic [DL_W-1:0]             decim_log2;
    logic [NUM_CH-1:0]           in_b;
    logic [NUM_CH*OUT_WIDTH-1:0] out_w;
    logic                        out_valid;
    logic                        out_ready;
    logic                        overrun;
    logic [NUM_CH-1:0]           sat;
    logic                        alt;

    int checks = 0;
    int errors = 0;

    cic_decim_param #(
        .ORDER         (ORDER),
        .MAX_DECIM_LOG2(MAXDL),
        .OUT_WIDTH     (OUT_WIDTH),
        .NUM_CH        (NUM_CH)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bipolar   (bipolar),
        .decim_log2(decim_log2),
        .in        (in_b),
        .out       (out_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks, landing 1 time unit after the edge; toggles ch0 in alternating mode.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (alt) in_b[0] = ~in_b[0];
        end
    endtask

    task automatic restart();
        enable = 1'b0;
        step(1);
        enable = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        bipolar    = 1'b0;
        decim_log2 = 4'd8;
        in_b       = 2'b00;
        out_ready  = 1'b1;
        alt        = 1'b0;
        step(2);
        check("rst_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_out", out_w, 0);
        check("rst_sat", sat, 0);
        reset = 1'b0;
        step(1);

        // Unipolar constant 1 on ch0, 0 on ch1: first load on tick 4 (cycle 1023).
        in_b   = 2'b01;
        enable = 1'b1;
        step(1023);
        check("uni1_warm", out_valid, 0);
        step(1);
        check("uni1_valid", out_valid, 1);
        check("uni1_ch0", $signed(out_w[15:0]), 32767);
        check("uni1_sat0", sat[0], 1);
        check("uni1_ch1", $signed(out_w[31:16]), 0);
        check("uni1_sat1", sat[1], 0);
        step(1);
        check("uni1_accept", out_valid, 0);
        step(255);
        check("uni1_tick5", out_valid, 1);
        check("uni1_tick5_ch0", $signed(out_w[15:0]), 32767);

        // Bipolar constant 0 on both channels: -2^24 >> 9.
        bipolar = 1'b1;
        in_b    = 2'b00;
        restart();
        step(1024);
        check("bip0_ch0", $signed(out_w[15:0]), -32768);
        check("bip0_ch1", $signed(out_w[31:16]), -32768);
        check("bip0_sat", sat, 0);

        // Bipolar alternating on ch0 averages to zero.
        alt = 1'b1;
        restart();
        step(1024);
        check("bipalt_ch0", $signed(out_w[15:0]), 0);
        check("bipalt_sat0", sat[0], 0);

        // Unipolar alternating: 2^23 >> 9.
        bipolar = 1'b0;
        restart();
        step(1024);
        check("unialt_ch0", $signed(out_w[15:0]), 16384);
        check("unialt_sat0", sat[0], 0);

        // decim_log2=0 clamps to 1: tick every 2 cycles, 8 << 12 clips.
        alt        = 1'b0;
        in_b       = 2'b01;
        decim_log2 = 4'd0;
        restart();
        step(7);
        check("dl1_warm", out_valid, 0);
        step(1);
        check("dl1_valid", out_valid, 1);
        check("dl1_ch0", $signed(out_w[15:0]), 32767);
        check("dl1_sat0", sat[0], 1);

        // 15 clamps to 8: change tick still loads, then 3 suppressed ticks at the new rate.
        decim_log2 = 4'd15;
        step(2);
        check("chg_tick_valid", out_valid, 1);
        step(1023);
        check("chg_suppressed", out_valid, 0);
        step(1);
        check("chg_valid", out_valid, 1);
        check("chg_ch0", $signed(out_w[15:0]), 32767);

        // Overrun: ready low, input drops to 0 after first load; third load holds c=7.
        decim_log2 = 4'd1;
        out_ready  = 1'b0;
        restart();
        step(8);
        check("ovr_first_valid", out_valid, 1);
        check("ovr_first_flag", overrun, 0);
        in_b = 2'b00;
        step(2);
        check("ovr_set", overrun, 1);
        step(2);
        check("ovr_sticky", overrun, 1);
        check("ovr_valid", out_valid, 1);
        check("ovr_ch0", $signed(out_w[15:0]), 28672);
        check("ovr_sat0", sat[0], 0);
        enable = 1'b0;
        step(1);
        check("en_low_overrun", overrun, 0);
        check("en_low_valid", out_valid, 0);
        check("en_low_out_hold", $signed(out_w[15:0]), 28672);

        // Reset mid-frame clears outputs at once; counter restarts from zero.
        in_b       = 2'b01;
        decim_log2 = 4'd8;
        out_ready  = 1'b1;
        restart();
        step(100);
        reset = 1'b1;
        #1;
        check("midrst_out", out_w, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_sat", sat, 0);
        check("midrst_overrun", overrun, 0);
        step(2);
        reset = 1'b0;
        step(1023);
        check("midrst_warm", out_valid, 0);
        step(1);
        check("midrst_valid_tick4", out_valid, 1);
        check("midrst_ch0", $signed(out_w[15:0]), 32767);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
